// File: rtl/div_pkg.sv
// div_pkg: types and helpers shared by the restoring divider and its
// reconstructor.
//   div_state_e  - IDLE / RUN / DONE state encoding, common to both FSMs
//   DIV_WIDTH    - default operand width
//   acc_overflow - true when a double-width accumulator exceeds WIDTH bits
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 8;

    // The caller zero-extends its accumulator to 64 bits. This supports
    // WIDTH values up to 32.
    function automatic logic acc_overflow(input logic [63:0] acc, input int width);
        return |(acc >> width);
    endfunction

endpackage

// File: rtl/div_reconstructor_if.sv
// div_reconstructor_if: start/ok/err handshake bundle for the reconstructor.
//   start      - level request from the master
//   D, B, R    - quotient, divisor and remainder operands from the master
//   A          - reconstructed dividend from the slave
//   ok, err    - result status from the slave, held until the next accept
//   busy       - slave is iterating
interface div_reconstructor_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] A;
    logic             ok;
    logic             err;
    logic             busy;

    modport master (output start, D, B, R, input  A, ok, err, busy);
    modport slave  (input  start, D, B, R, output A, ok, err, busy);
endinterface

// File: rtl/div_reconstructor_shift_add_step.sv
// shift_add_step: one combinational iteration of the shift-add multiplier.
//   acc_i    - current 2*WIDTH accumulator
//   mc_i     - multiplicand (divisor)
//   md_bit_i - current multiplier bit (quotient LSB after shifting)
//   count_i  - iteration index, which sets the multiplicand weight
//   acc_o    - accumulator after this iteration
module shift_add_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   mc_i,
    input  logic               md_bit_i,
    input  logic [CW-1:0]      count_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [2*WIDTH-1:0] addend;

    // The multiplicand is widened before the shift so that no product
    // bits are lost.
    assign addend = {{WIDTH{1'b0}}, mc_i} << count_i;
    assign acc_o  = md_bit_i ? (acc_i + addend) : acc_i;
endmodule

// File: rtl/div_reconstructor.sv
// div_reconstructor: rebuilds the dividend as A = D*B + R. It uses a
// shift-add loop that consumes one quotient bit per clock.
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high
//   bus   - slave side of div_reconstructor_if (start/D/B/R in, A/ok/err/busy out)
// Results appear WIDTH edges after the accept edge. Invalid operands
// (B==0 or R>=B) finish on the accept edge itself with err set.
module div_reconstructor
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    div_reconstructor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e         state_q;
    logic [WIDTH-1:0]   md_q;
    logic [WIDTH-1:0]   mc_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   a_q;
    logic               ok_q;
    logic               err_q;
    logic               busy_q;

    shift_add_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
        .acc_i    (acc_q),
        .mc_i     (mc_q),
        .md_bit_i (md_q[0]),
        .count_i  (count_q),
        .acc_o    (acc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            md_q    <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            count_q <= '0;
            a_q     <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // DONE behaves as idle. If start stays high, the next
                    // operation begins right after completion.
                    if (bus.start) begin
                        md_q    <= bus.D;
                        mc_q    <= bus.B;
                        acc_q   <= {{WIDTH{1'b0}}, bus.R};
                        count_q <= '0;
                        ok_q    <= 1'b0;
                        err_q   <= 1'b0;
                        if (bus.B == '0 || bus.R >= bus.B) begin
                            // A valid divider never produces these
                            // operands, so reject them immediately.
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            a_q     <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    md_q    <= md_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        // The result is taken from the step output, so the
                        // last partial product lands on this same edge.
                        a_q     <= acc_d[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                        if (acc_overflow({{(64-2*WIDTH){1'b0}}, acc_d}, WIDTH)) begin
                            err_q <= 1'b1;
                            ok_q  <= 1'b0;
                        end else begin
                            ok_q  <= 1'b1;
                            err_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A    = a_q;
    assign bus.ok   = ok_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_div_reconstructor.sv
// tb_div_reconstructor: directed self-checking bench for div_reconstructor.
module tb_div_reconstructor;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   lat;

    logic [7:0] blist [8] = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd13, 8'd16, 8'd100, 8'd255};

    div_reconstructor_if #(.WIDTH(8)) bus_if ();

    div_reconstructor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation with a single-cycle start pulse. lat counts the edges
    // after the accept edge until busy drops, with a bounded wait.
    task automatic do_op(input logic [7:0] d, input logic [7:0] b, input logic [7:0] r,
                         output int lat_o);
        bus_if.D = d;
        bus_if.B = b;
        bus_if.R = r;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        lat_o = 0;
        while (bus_if.busy === 1'b1 && lat_o < 40) begin
            tick();
            lat_o++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.D = '0;
        bus_if.B = '0;
        bus_if.R = '0;

        // Reset
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset_A", bus_if.A, 0);
        check("reset_ok", bus_if.ok, 0);
        check("reset_err", bus_if.err, 0);
        check("reset_busy", bus_if.busy, 0);

        // 12*10+7 = 127, with busy checked each cycle
        bus_if.D = 8'd12; bus_if.B = 8'd10; bus_if.R = 8'd7;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        check("basic_busy_accept", bus_if.busy, 1);
        check("basic_ok_accept", bus_if.ok, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("basic_busy_run", bus_if.busy, 1);
            check("basic_A_hold", bus_if.A, 0);
        end
        tick();
        check("basic_busy_done", bus_if.busy, 0);
        check("basic_A", bus_if.A, 127);
        check("basic_ok", bus_if.ok, 1);
        check("basic_err", bus_if.err, 0);
        tick(); tick(); tick();
        check("basic_A_held", bus_if.A, 127);
        check("basic_ok_held", bus_if.ok, 1);

        // Overflow: 25*11+3 = 278, and 278 mod 256 = 22
        do_op(8'd25, 8'd11, 8'd3, lat);
        check("ovf_latency", lat, 8);
        check("ovf_A", bus_if.A, 22);
        check("ovf_err", bus_if.err, 1);
        check("ovf_ok", bus_if.ok, 0);

        // Reset during a run, then redo the same operation
        bus_if.D = 8'd255; bus_if.B = 8'd1; bus_if.R = 8'd0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        check("abort_err_cleared", bus_if.err, 0);
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        check("abort_A", bus_if.A, 0);
        check("abort_ok", bus_if.ok, 0);
        check("abort_busy", bus_if.busy, 0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_no_result", bus_if.ok, 0);
        do_op(8'd255, 8'd1, 8'd0, lat);
        check("redo_latency", lat, 8);
        check("redo_A", bus_if.A, 255);
        check("redo_ok", bus_if.ok, 1);

        // Error fast path when B == 0
        do_op(8'd9, 8'd0, 8'd3, lat);
        check("b0_latency", lat, 0);
        check("b0_err", bus_if.err, 1);
        check("b0_ok", bus_if.ok, 0);
        check("b0_A", bus_if.A, 0);

        // Error fast path when R >= B
        do_op(8'd12, 8'd10, 8'd7, lat);
        check("pre_rge_A", bus_if.A, 127);
        do_op(8'd5, 8'd4, 8'd4, lat);
        check("rge_latency", lat, 0);
        check("rge_err", bus_if.err, 1);
        check("rge_A", bus_if.A, 0);
        check("rge_busy", bus_if.busy, 0);

        // Closed loop against divider results, with start held high and
        // operands scrambled during RUN
        bus_if.start = 1'b1;
        for (int ai = 0; ai <= 255; ai = (ai == 252) ? 255 : ai + 7) begin
            for (int k = 0; k < 8; k++) begin
                bus_if.B = blist[k];
                bus_if.D = 8'(ai / int'(blist[k]));
                bus_if.R = 8'(ai % int'(blist[k]));
                tick();
                bus_if.D = 8'hA5;
                bus_if.B = 8'h00;
                bus_if.R = 8'hFF;
                lat = 0;
                while (bus_if.busy === 1'b1 && lat < 40) begin
                    tick();
                    lat++;
                end
                check($sformatf("loop_A a=%0d b=%0d", ai, blist[k]), bus_if.A, ai);
                check($sformatf("loop_ok a=%0d b=%0d lat=%0d", ai, blist[k], lat),
                      {bus_if.ok, bus_if.err}, 2'b10);
            end
        end
        bus_if.start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
